// File: rtl/ts_pkt_scheduler_if.sv
// ----------------------------------------------------------------------------
// ts_pkt_scheduler_if
// Handshake between one MPEG-TS byte source and the packet scheduler.
//
//   req   : source -> scheduler, a complete packet is waiting
//   ready : scheduler -> source, a byte may be accepted this cycle
//   valid : source -> scheduler, data carries a byte
//   data  : source -> scheduler, the byte
//
// master : source side
// slave  : scheduler side
// ----------------------------------------------------------------------------
interface ts_pkt_scheduler_if;
  logic       req;
  logic       ready;
  logic       valid;
  logic [7:0] data;

  modport master (
    output req,
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  req,
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/ts_pkt_scheduler.sv
// ----------------------------------------------------------------------------
// ts_pkt_scheduler
// Packet-level scheduler in front of the ts2asi input port (din_clk domain).
// Two MPEG-TS byte sources are served round-robin, one whole packet at a
// time. When scheduling is enabled but neither source has a packet, null
// packets (PID 0x1FFF) keep the ASI stream filled. Byte emission in every
// state stalls while the ts2asi FIFO reports almost-full.
//
// Ports
//   din_clk            byte clock
//   rst_n              synchronous active-low reset
//   enable_i           scheduling allowed (looked at only in IDLE)
//   null_insert_en_i   null packets may be started from IDLE
//   fifo_almost_full_i back-pressure from the ts2asi FIFO
//   src0_if, src1_if   source handshakes (req/ready/valid/data)
//   out_valid_o        registered byte valid towards ts2asi
//   out_sync_o         high with the first byte of each packet
//   out_data_o         registered byte towards ts2asi
//   busy_o             a packet (source or null) is in progress
//   sync_err_o         one-cycle pulse with out_sync when a source packet
//                      does not start with 0x47
//   pkt_cnt0_o/1_o     packets forwarded from source 0 / source 1
//   null_cnt_o         null packets inserted
//
// PKT_LEN must lie in 8..255 so the byte index fits in 8 bits and the
// four-byte null header fits in a packet.
// ----------------------------------------------------------------------------
module ts_pkt_scheduler #(
  parameter int PKT_LEN   = 188,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 din_clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic                 null_insert_en_i,
  input  logic                 fifo_almost_full_i,
  ts_pkt_scheduler_if.slave    src0_if,
  ts_pkt_scheduler_if.slave    src1_if,
  output logic                 out_valid_o,
  output logic                 out_sync_o,
  output logic [7:0]           out_data_o,
  output logic                 busy_o,
  output logic                 sync_err_o,
  output logic [CNT_WIDTH-1:0] pkt_cnt0_o,
  output logic [CNT_WIDTH-1:0] pkt_cnt1_o,
  output logic [CNT_WIDTH-1:0] null_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS0 = 2'd1,
    ST_PASS1 = 2'd2,
    ST_NULL  = 2'd3
  } state_e;

  localparam logic [7:0]           LAST_IDX  = 8'(PKT_LEN - 1);
  localparam logic [7:0]           SYNC_BYTE = 8'h47;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  // Null packet content: sync byte, PID 0x1FFF with payload-only adaptation
  // field control (0x10), then 0xFF stuffing to the end of the packet.
  function automatic logic [7:0] null_byte(input logic [7:0] idx);
    logic [7:0] b;
    case (idx)
      8'd0:    b = 8'h47;
      8'd1:    b = 8'h1F;
      8'd2:    b = 8'hFF;
      8'd3:    b = 8'h10;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  state_e                 state_q;
  logic [7:0]             cnt_q;
  logic [7:0]             cnt_d;
  logic                   last_grant_q;   // 0 = source 0 won last, 1 = source 1
  logic                   out_valid_q;
  logic                   out_sync_q;
  logic [7:0]             out_data_q;
  logic                   sync_err_q;
  logic [CNT_WIDTH-1:0]   pkt_cnt0_q;
  logic [CNT_WIDTH-1:0]   pkt_cnt1_q;
  logic [CNT_WIDTH-1:0]   null_cnt_q;

  logic                   xfer_s;         // a byte moves this cycle
  logic [7:0]             byte_s;         // the byte that moves
  logic                   first_s;        // current byte index is 0
  logic                   last_s;         // current byte index is PKT_LEN-1

  // Ready is a pure function of the state register and the back-pressure
  // input, so a source sees it in the same cycle the FIFO fills.
  assign src0_if.ready = (state_q == ST_PASS0) && !fifo_almost_full_i;
  assign src1_if.ready = (state_q == ST_PASS1) && !fifo_almost_full_i;

  // Pick the byte that moves this cycle and compute the next byte index.
  always_comb begin
    xfer_s = 1'b0;
    byte_s = 8'h00;
    case (state_q)
      ST_PASS0: begin
        xfer_s = src0_if.valid && src0_if.ready;
        byte_s = src0_if.data;
      end
      ST_PASS1: begin
        xfer_s = src1_if.valid && src1_if.ready;
        byte_s = src1_if.data;
      end
      ST_NULL: begin
        xfer_s = !fifo_almost_full_i;
        byte_s = null_byte(cnt_q);
      end
      default: begin
        xfer_s = 1'b0;
        byte_s = 8'h00;
      end
    endcase
    first_s = (cnt_q == 8'd0);
    last_s  = (cnt_q == LAST_IDX);
    if (last_s) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Scheduler FSM, byte counter, output register and statistics.
  always_ff @(posedge din_clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      last_grant_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_sync_q   <= 1'b0;
      out_data_q   <= 8'h00;
      sync_err_q   <= 1'b0;
      pkt_cnt0_q   <= '0;
      pkt_cnt1_q   <= '0;
      null_cnt_q   <= '0;
    end else begin
      // One-cycle output latency: whatever moved this cycle is presented next.
      out_valid_q <= xfer_s;
      out_sync_q  <= xfer_s && first_s;
      // Null packets always start with 0x47, so only source bytes can flag.
      sync_err_q  <= xfer_s && first_s && (byte_s != SYNC_BYTE) && (state_q != ST_NULL);
      if (xfer_s) begin
        out_data_q <= byte_s;
        cnt_q      <= cnt_d;
      end

      case (state_q)
        ST_IDLE: begin
          // Requests are only looked at here, so at least one IDLE cycle
          // separates consecutive packets.
          if (enable_i && (src0_if.req || src1_if.req)) begin
            if (src0_if.req && (!src1_if.req || last_grant_q)) begin
              state_q      <= ST_PASS0;
              last_grant_q <= 1'b0;
            end else begin
              state_q      <= ST_PASS1;
              last_grant_q <= 1'b1;
            end
          end else if (enable_i && null_insert_en_i) begin
            state_q <= ST_NULL;
          end
        end
        ST_PASS0: begin
          if (xfer_s && last_s) begin
            pkt_cnt0_q <= pkt_cnt0_q + CNT_ONE;
            state_q    <= ST_IDLE;
          end
        end
        ST_PASS1: begin
          if (xfer_s && last_s) begin
            pkt_cnt1_q <= pkt_cnt1_q + CNT_ONE;
            state_q    <= ST_IDLE;
          end
        end
        ST_NULL: begin
          if (xfer_s && last_s) begin
            null_cnt_q <= null_cnt_q + CNT_ONE;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_sync_o  = out_sync_q;
  assign out_data_o  = out_data_q;
  assign sync_err_o  = sync_err_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign pkt_cnt0_o  = pkt_cnt0_q;
  assign pkt_cnt1_o  = pkt_cnt1_q;
  assign null_cnt_o  = null_cnt_q;

endmodule
